// File: rtl/riscv_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// riscv_wb_arbiter_if
//   Bundles the writeback-arbiter signals. These are the two result lanes
//   from the dual-issue core, the shared register-file write port and the
//   two hazard-query ports used by issue logic.
//
//   slave  : the arbiter side. Lanes and query addresses are inputs.
//            in_ready, the write port and the pend flags are outputs.
//   master : the producer/consumer side, which is the mirror image.
// ---------------------------------------------------------------------------
interface riscv_wb_arbiter_if #(
    parameter int XLEN = 32
);
    // Lane A (older) and lane B (younger) results
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            in_ready;

    // Register-file write port
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;

    // Hazard queries
    logic [4:0]      q0_addr;
    logic            q0_pend;
    logic [4:0]      q1_addr;
    logic            q1_pend;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  q0_addr, q1_addr,
        output in_ready, wr_en, wr_addr, wr_data, q0_pend, q1_pend
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output q0_addr, q1_addr,
        input  in_ready, wr_en, wr_addr, wr_data, q0_pend, q1_pend
    );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_wb_arbiter
//   Shares the single register-file write port between the two writeback
//   lanes of a dual-issue core. Accepted results enter a small in-order
//   circular FIFO in lane order, with A before B. One result is drained
//   per cycle. Pending destinations can be queried so issue logic can
//   stall on RAW hazards.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : riscv_wb_arbiter_if.slave, which carries the lane inputs,
//              in_ready, the regfile write port and the hazard queries
//
//   Parameters
//     DEPTH  : FIFO entries, a power of two and >= 2
//     XLEN   : data width
// ---------------------------------------------------------------------------
module riscv_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscv_wb_arbiter_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      rd_q    [DEPTH];
    logic [XLEN-1:0] data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            in_ready;
    logic            a_acc, b_acc, pop;
    logic [PW-1:0]   slot_a, slot_b;

    // Next-state and acceptance logic.
    // in_ready guarantees at least two free slots. Because of that, a push
    // can never land on the head entry that is being popped in the same cycle.
    always_comb begin
        in_ready = (count_q <= CW'(DEPTH - 2));
        a_acc    = bus.a_valid && in_ready && (bus.a_rd != 5'd0);
        b_acc    = bus.b_valid && in_ready && (bus.b_rd != 5'd0);
        pop      = (count_q != '0);

        slot_a   = wr_ptr_q;
        // B takes the next slot only when A actually consumed wr_ptr
        slot_b   = a_acc ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

        wr_ptr_d = wr_ptr_q + PW'(a_acc) + PW'(b_acc);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(a_acc) + CW'(b_acc) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage. The pop-clear comes first so that a push to a freshly
    // freed slot wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (a_acc) begin
                rd_q[slot_a]    <= bus.a_rd;
                data_q[slot_a]  <= bus.a_data;
                valid_q[slot_a] <= 1'b1;
            end
            if (b_acc) begin
                rd_q[slot_b]    <= bus.b_rd;
                data_q[slot_b]  <= bus.b_data;
                valid_q[slot_b] <= 1'b1;
            end
        end
    end

    // Hazard match per entry. The head that is being written still counts
    // as pending. Same-cycle enqueues are not visible here.
    logic [DEPTH-1:0] hit0, hit1;
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit0[gi] = valid_q[gi] && (rd_q[gi] == bus.q0_addr);
            assign hit1[gi] = valid_q[gi] && (rd_q[gi] == bus.q1_addr);
        end
    endgenerate

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = pop;
    assign bus.wr_addr  = pop ? rd_q[rd_ptr_q]   : 5'd0;
    assign bus.wr_data  = pop ? data_q[rd_ptr_q] : '0;
    assign bus.q0_pend  = (bus.q0_addr != 5'd0) && (|hit0);
    assign bus.q1_pend  = (bus.q1_addr != 5'd0) && (|hit1);

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_wb_arbiter
//   Directed stimulus with a scoreboard queue. Expected writes are pushed
//   when lanes are driven and popped as the arbiter drains them. Every
//   cycle the bench checks the write port, in_ready and both pend flags.
// ---------------------------------------------------------------------------
module tb_riscv_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk;
    logic rst_n;

    riscv_wb_arbiter_if #(.XLEN(XLEN)) wb ();

    riscv_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (sb[i]) if (sb[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: drive inputs at the falling edge, check the outputs, then
    // advance the model across the rising edge.
    task automatic cyc(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic [4:0] q0, input logic [4:0] q1);
        bit rdy;
        wb.a_valid = av;  wb.a_rd = ard;  wb.a_data = ad;
        wb.b_valid = bv;  wb.b_rd = brd;  wb.b_data = bd;
        wb.q0_addr = q0;  wb.q1_addr = q1;
        #1;
        rdy = (sb.size() <= DEPTH - 2);
        chk("wr_en", {31'd0, wb.wr_en}, {31'd0, sb.size() != 0});
        if (sb.size() != 0) begin
            chk("wr_addr", {27'd0, wb.wr_addr}, {27'd0, sb[0].rd});
            chk("wr_data", wb.wr_data, sb[0].d);
        end else begin
            chk("wr_addr_idle", {27'd0, wb.wr_addr}, 32'd0);
            chk("wr_data_idle", wb.wr_data, 32'd0);
        end
        chk("in_ready", {31'd0, wb.in_ready}, {31'd0, rdy});
        chk("q0_pend", {31'd0, wb.q0_pend}, {31'd0, model_pend(q0)});
        chk("q1_pend", {31'd0, wb.q1_pend}, {31'd0, model_pend(q1)});
        if (av || bv) chk("proto_in_ready", {31'd0, wb.in_ready}, 32'd1);
        $display("cyc t=%0t a=%0b/%0d/%h b=%0b/%0d/%h wr_en=%0b wr=%0d/%h rdy=%0b sb=%0d",
                 $time, av, ard, ad, bv, brd, bd, wb.wr_en, wb.wr_addr, wb.wr_data,
                 wb.in_ready, sb.size());
        @(posedge clk);
        if (sb.size() != 0) void'(sb.pop_front());
        if (av && rdy && ard != 5'd0) sb.push_back('{rd: ard, d: ad});
        if (bv && rdy && brd != 5'd0) sb.push_back('{rd: brd, d: bd});
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] q0, input logic [4:0] q1);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, q0, q1);
    endtask

    initial begin
        rst_n = 1'b0;
        wb.a_valid = 0; wb.a_rd = 0; wb.a_data = 0;
        wb.b_valid = 0; wb.b_rd = 0; wb.b_data = 0;
        wb.q0_addr = 5'd5; wb.q1_addr = 5'd0;
        repeat (2) @(negedge clk);
        // Outputs held in reset
        chk("rst_wr_en",    {31'd0, wb.wr_en},    32'd0);
        chk("rst_wr_addr",  {27'd0, wb.wr_addr},  32'd0);
        chk("rst_wr_data",  wb.wr_data,           32'd0);
        chk("rst_in_ready", {31'd0, wb.in_ready}, 32'd1);
        chk("rst_q0_pend",  {31'd0, wb.q0_pend},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single write
        cyc(1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 5'd5, 5'd0);
        idle(3, 5'd5, 5'd0);

        // 2: pair to the same rd, A then B
        cyc(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 5'd7, 5'd0);
        idle(3, 5'd7, 5'd0);

        // 3: the x0 result is dropped
        cyc(1, 5'd0, 32'hFFFF, 1, 5'd3, 32'h33, 5'd3, 5'd0);
        idle(2, 5'd3, 5'd0);

        // 4: fill while in_ready allows
        for (int k = 0; k < 3; k++) begin
            if (sb.size() <= DEPTH - 2)
                cyc(1, 5'(10 + 2 * k), 32'h100 + k, 1, 5'(11 + 2 * k), 32'h200 + k, 5'd10, 5'd13);
            else
                idle(1, 5'd10, 5'd13);
        end
        idle(5, 5'd11, 5'd12);

        // 5: count=1, push2 + pop1
        cyc(1, 5'd4, 32'h40, 0, 0, 0, 5'd4, 5'd9);
        cyc(1, 5'd8, 32'h80, 1, 5'd9, 32'h90, 5'd4, 5'd9);
        idle(3, 5'd8, 5'd9);

        // 6: reset with three entries queued
        cyc(1, 5'd20, 32'h20, 1, 5'd21, 32'h21, 5'd20, 5'd21);
        cyc(1, 5'd22, 32'h22, 1, 5'd23, 32'h23, 5'd20, 5'd21);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en",    {31'd0, wb.wr_en},    32'd0);
        chk("mid_rst_in_ready", {31'd0, wb.in_ready}, 32'd1);
        chk("mid_rst_wr_addr",  {27'd0, wb.wr_addr},  32'd0);
        chk("mid_rst_q0_pend",  {31'd0, wb.q0_pend},  32'd0);
        chk("mid_rst_q1_pend",  {31'd0, wb.q1_pend},  32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 5'd6, 32'h66, 5'd22, 5'd6);
        idle(2, 5'd6, 5'd22);

        // Mixed traffic, including rd=0 lanes, offered only when ready
        for (int k = 0; k < 30; k++) begin
            bit go;
            go = (sb.size() <= DEPTH - 2);
            cyc(go && $urandom_range(1, 0) == 1, 5'($urandom_range(31, 0)), $urandom,
                go && $urandom_range(1, 0) == 1, 5'($urandom_range(31, 0)), $urandom,
                5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
        end
        idle(5, 5'd0, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
